// File: rtl/anffl_mem_rd_responder.sv
// Read responder for the MEM read bus: accepts 1..4 word read requests, serves
// them from a synchronous SRAM (one-cycle read latency) and returns one beat per
// cycle with last/err markers. Issue-to-return latency is fixed at two cycles.
module anffl_mem_rd_responder #(
  parameter int unsigned WORDS_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_rd_req,
  input  logic [31:0]           mem_rd_addr,
  input  logic [1:0]            mem_rd_burst,
  output logic                  mem_rd_ack,
  output logic                  mem_rd_valid,
  output logic [31:0]           mem_rd_data,
  output logic                  mem_rd_last,
  output logic                  mem_rd_err,
  output logic                  sram_rd_en,
  output logic [WORDS_LOG2-1:0] sram_addr,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  // Window size in bytes; 33 bits so offsets that wrapped below BASE_ADDR stay out of range.
  localparam logic [32:0] WinBytes = 33'd4 << WORDS_LOG2;

  state_e      state_q, state_d;
  logic [31:0] off_q, off_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  len_q, len_d;
  logic        mis_q, mis_d;

  // Tag travelling alongside the SRAM access.
  logic        tag_valid_q, tag_valid_d;
  logic        tag_last_q, tag_last_d;
  logic        tag_err_q, tag_err_d;

  // Registered return beat.
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  logic        issuing;
  logic        last_beat;
  logic        in_range;
  logic [32:0] byte_off;

  // Issue-stage decode: current beat address and whether it may touch the SRAM.
  always_comb begin
    issuing    = (state_q == StIssue);
    last_beat  = (cnt_q == len_q);
    byte_off   = {1'b0, off_q} + {29'd0, cnt_q, 2'b00};
    in_range   = (byte_off < WinBytes) && !mis_q;
    mem_rd_ack = mem_rd_req && reset && ((state_q == StIdle) || (issuing && last_beat));
    sram_rd_en = issuing && in_range;
    sram_addr  = sram_rd_en ? byte_off[WORDS_LOG2+1:2] : '0;
  end

  // Request acceptance and beat sequencing.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mis_d   = mis_q;
    if (mem_rd_ack) begin
      off_d   = mem_rd_addr - BASE_ADDR;
      len_d   = mem_rd_burst;
      mis_d   = |mem_rd_addr[1:0];
      cnt_d   = 2'd0;
      state_d = StIssue;
    end else if (issuing) begin
      if (last_beat) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Pipeline: tag follows the SRAM read, then the beat is registered onto the bus.
  always_comb begin
    tag_valid_d = issuing;
    tag_last_d  = issuing && last_beat;
    tag_err_d   = issuing && !in_range;
    valid_d     = tag_valid_q;
    last_d      = tag_last_q;
    err_d       = tag_err_q;
    data_d      = (tag_valid_q && !tag_err_q) ? sram_rdata : 32'd0;
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      off_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      mis_q       <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mis_q       <= mis_d;
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
      tag_err_q   <= tag_err_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      data_q      <= data_d;
    end
  end

  assign mem_rd_valid = valid_q;
  assign mem_rd_data  = data_q;
  assign mem_rd_last  = last_q;
  assign mem_rd_err   = err_q;

endmodule
